// File: rtl/conv_window_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : conv_seq_pkg
// Description : Shared state encoding and width helpers for the conv window
//               sequencer and its address generator.
// Revision    : 1.0 - initial release
// ============================================================================
package conv_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    EVAL  = 3'd3,
    OUT   = 3'd4,
    FIN   = 3'd5
  } state_t;

  // Ceiling log2, never less than 1 so that every derived bus has a bit.
  function automatic int clog2u(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Width of a full-precision sum of n products of two width-bit operands.
  function automatic int zw_width(input int width, input int n);
    return 2 * width + clog2u(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_window_sequencer_win_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : win_addr_gen
// Description : Window/kernel position counters and RAM address generation.
//               Addresses are built incrementally from base registers so no
//               multiplier is needed.
// Revision    : 1.0 - initial release
// ============================================================================
module win_addr_gen
  import conv_seq_pkg::*;
#(
  parameter int F     = 5,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  parameter int AW    = 10,
  parameter int OAW   = 10,
  parameter int KIW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           step,
  input  logic           next_window,
  output logic [AW-1:0]  rd_addr,
  output logic [KIW-1:0] k_idx,
  output logic           last_k,
  output logic           last_window,
  output logic [OAW-1:0] pos
);

  localparam int OW = IMG_W - F + 1;
  localparam int OH = IMG_H - F + 1;
  localparam int XW = clog2u(OW);
  localparam int YW = clog2u(OH);
  localparam int KW = clog2u(F);

  logic [XW-1:0] r_ox;
  logic [YW-1:0] r_oy;
  logic [KW-1:0] r_kx;
  logic [KW-1:0] r_ky;
  logic [AW-1:0] r_line_base;  // oy*IMG_W
  logic [AW-1:0] r_win_base;   // oy*IMG_W + ox
  logic [AW-1:0] r_row_base;   // (oy+ky)*IMG_W + ox

  assign last_k      = (r_kx == KW'(F - 1)) && (r_ky == KW'(F - 1));
  assign last_window = (r_ox == XW'(OW - 1)) && (r_oy == YW'(OH - 1));
  assign rd_addr     = r_row_base + AW'(r_kx);

  // Kernel stepping during fetch, window stepping on each accepted result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ox        <= '0;
      r_oy        <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      k_idx       <= '0;
      r_line_base <= '0;
      r_win_base  <= '0;
      r_row_base  <= '0;
      pos         <= '0;
    end else if (clear || (next_window && last_window)) begin
      r_ox        <= '0;
      r_oy        <= '0;
      r_kx        <= '0;
      r_ky        <= '0;
      k_idx       <= '0;
      r_line_base <= '0;
      r_win_base  <= '0;
      r_row_base  <= '0;
      pos         <= '0;
    end else if (next_window) begin
      pos <= pos + OAW'(1);
      if (r_ox == XW'(OW - 1)) begin
        r_ox        <= '0;
        r_oy        <= r_oy + YW'(1);
        r_line_base <= r_line_base + AW'(IMG_W);
        r_win_base  <= r_line_base + AW'(IMG_W);
        r_row_base  <= r_line_base + AW'(IMG_W);
      end else begin
        r_ox       <= r_ox + XW'(1);
        r_win_base <= r_win_base + AW'(1);
        r_row_base <= r_win_base + AW'(1);
      end
    end else if (step) begin
      k_idx <= last_k ? '0 : k_idx + KIW'(1);
      if (r_kx == KW'(F - 1)) begin
        r_kx <= '0;
        if (r_ky == KW'(F - 1)) begin
          r_ky       <= '0;
          r_row_base <= r_win_base;
        end else begin
          r_ky       <= r_ky + KW'(1);
          r_row_base <= r_row_base + AW'(IMG_W);
        end
      end else begin
        r_kx <= r_kx + KW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_sequencer
// Description : Walks an FxF window over the input map, gathers each window
//               from RAM, presents it to a combinational conv layer and hands
//               the registered result downstream over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_sequencer
  import conv_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int F     = 5,
  parameter int CIN   = 3,
  parameter int IMG_W = 32,
  parameter int IMG_H = 32,
  localparam int OW   = IMG_W - F + 1,
  localparam int OH   = IMG_H - F + 1,
  localparam int N    = CIN * F * F,
  localparam int ZW   = zw_width(WIDTH, N),
  localparam int AW   = clog2u(IMG_W * IMG_H),
  localparam int OAW  = clog2u(OW * OH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 rd_en,
  output logic [AW-1:0]        rd_addr,
  input  logic [CIN*WIDTH-1:0] rd_data,
  output logic [N*WIDTH-1:0]   win_x,
  output logic                 win_valid,
  input  logic [ZW-1:0]        layer_z,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ZW-1:0]        out_data,
  output logic [OAW-1:0]       out_addr
);

  localparam int KIW = clog2u(F * F);

  state_t           r_state;
  state_t           w_next;
  logic             w_clear;
  logic             w_step;
  logic             w_next_window;
  logic [KIW-1:0]   w_k_idx;
  logic             w_last_k;
  logic             w_last_window;
  logic [OAW-1:0]   w_pos;
  logic             r_cap_en;
  logic [KIW-1:0]   r_cap_k;

  win_addr_gen #(
    .F     (F),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .AW    (AW),
    .OAW   (OAW),
    .KIW   (KIW)
  ) u_addr (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (w_clear),
    .step        (w_step),
    .next_window (w_next_window),
    .rd_addr     (rd_addr),
    .k_idx       (w_k_idx),
    .last_k      (w_last_k),
    .last_window (w_last_window),
    .pos         (w_pos)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode and counter controls.
  always_comb begin
    w_next        = r_state;
    w_clear       = 1'b0;
    w_step        = 1'b0;
    w_next_window = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next  = FETCH;
          w_clear = 1'b1;
        end
      end
      FETCH: begin
        w_step = 1'b1;
        if (w_last_k) w_next = DRAIN;
      end
      DRAIN: w_next = EVAL;
      EVAL:  w_next = OUT;
      OUT: begin
        if (out_ready) begin
          w_next_window = 1'b1;
          w_next        = w_last_window ? FIN : FETCH;
        end
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign busy      = (r_state == FETCH) || (r_state == DRAIN) ||
                     (r_state == EVAL)  || (r_state == OUT);
  assign done      = (r_state == FIN);
  assign rd_en     = (r_state == FETCH);
  assign win_valid = (r_state == EVAL);
  assign out_valid = (r_state == OUT);

  // Read data lags the strobe by one cycle, so the slot index is delayed too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_en <= 1'b0;
      r_cap_k  <= '0;
      win_x    <= '0;
    end else begin
      r_cap_en <= rd_en;
      r_cap_k  <= w_k_idx;
      if (r_cap_en) begin
        for (int c = 0; c < CIN; c++) begin
          win_x[(c * F * F + int'(r_cap_k)) * WIDTH +: WIDTH] <= rd_data[c * WIDTH +: WIDTH];
        end
      end
    end
  end

  // Result register, loaded once per window while the window is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_addr <= '0;
    end else if (r_state == EVAL) begin
      out_data <= layer_z;
      out_addr <= w_pos;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_window_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_sequencer
// Description : Self-checking bench for conv_window_sequencer (6x6 map plus
//               an 8x8 instance for the address sweep).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_sequencer;
  import conv_seq_pkg::*;

  localparam int WIDTH = 8;
  localparam int F     = 5;
  localparam int CIN   = 3;
  localparam int N     = CIN * F * F;
  localparam int ZW    = zw_width(WIDTH, N);
  localparam int AW    = clog2u(36);
  localparam int OAW   = clog2u(4);
  localparam int AW8   = clog2u(64);
  localparam int OAW8  = clog2u(16);
  localparam int PASS_CYC = 4 * (F * F + 3) + 1;

  typedef struct packed {
    logic [OAW-1:0] addr;
    logic [ZW-1:0]  data;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic                 busy, done, rd_en, win_valid, out_valid, out_ready;
  logic [AW-1:0]        rd_addr;
  logic [CIN*WIDTH-1:0] rd_data;
  logic [N*WIDTH-1:0]   win_x;
  logic [ZW-1:0]        layer_z, out_data;
  logic [OAW-1:0]       out_addr;

  logic                 start8;
  logic                 busy8, done8, rd_en8, win_valid8, out_valid8, out_ready8;
  logic [AW8-1:0]       rd_addr8;
  logic [CIN*WIDTH-1:0] rd_data8;
  logic [N*WIDTH-1:0]   win_x8;
  logic [ZW-1:0]        layer_z8, out_data8;
  logic [OAW8-1:0]      out_addr8;

  always #5 clk = ~clk;

  conv_window_sequencer #(.WIDTH(WIDTH), .F(F), .CIN(CIN), .IMG_W(6), .IMG_H(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win_x(win_x),
    .win_valid(win_valid), .layer_z(layer_z), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr)
  );

  conv_window_sequencer #(.WIDTH(WIDTH), .F(F), .CIN(CIN), .IMG_W(8), .IMG_H(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .busy(busy8), .done(done8),
    .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8), .win_x(win_x8),
    .win_valid(win_valid8), .layer_z(layer_z8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .out_addr(out_addr8)
  );

  // RAM models: each word holds its own low address byte in every channel.
  always @(posedge clk) begin
    if (rd_en)  rd_data  <= {CIN{8'(rd_addr)}};
    if (rd_en8) rd_data8 <= {CIN{8'(rd_addr8)}};
  end

  // Layer model: plain signed sum of the window samples.
  always_comb begin
    logic signed [WIDTH-1:0] s;
    layer_z = '0;
    for (int i = 0; i < N; i++) begin
      s = win_x[i*WIDTH +: WIDTH];
      layer_z = layer_z + ZW'(s);
    end
  end
  assign layer_z8 = '0;

  task automatic push_pass();
    exp_t e;
    int   s;
    for (int oy = 0; oy < 2; oy++) begin
      for (int ox = 0; ox < 2; ox++) begin
        s = 0;
        for (int ky = 0; ky < F; ky++)
          for (int kx = 0; kx < F; kx++)
            s += (oy + ky) * 6 + ox + kx;
        e.addr = OAW'(oy * 2 + ox);
        e.data = ZW'(3 * s);
        q.push_back(e);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start     = 1'($urandom);
      out_ready = 1'($urandom);
    end
    total++; if ({busy, done, rd_en, win_valid, out_valid} !== 5'b0) begin bad++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, rd_en, win_valid, out_valid}); end
    total++; if (rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr: got %0d want 0", rd_addr); end
    total++; if (win_x !== '0) begin bad++; $display("FAIL reset_win_x: got nonzero want 0"); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
    total++; if (out_addr !== '0) begin bad++; $display("FAIL reset_out_addr: got %0d want 0", out_addr); end
    start = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ({busy, rd_en, done} !== 3'b0) begin bad++; $display("FAIL idle_after_reset: got %b want 000", {busy, rd_en, done}); end
  endtask

  task automatic test_small_map();
    exp_t e;
    int   cnt = 0, nx = 0, last_x = -1, done_cnt = -1;
    q.delete();
    push_pass();
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    for (int i = 0; i < PASS_CYC + 20; i++) begin
      @(negedge clk);
      cnt++;
      start = 1'b0;
      if (out_valid && out_ready) begin
        nx++; last_x = cnt; total++;
        if (q.size() == 0) begin bad++; $display("FAIL small_result: unexpected addr=%0d", out_addr); end
        else begin
          e = q.pop_front();
          if (out_addr !== e.addr || out_data !== e.data) begin bad++; $display("FAIL small_result: got addr=%0d data=%0d want addr=%0d data=%0d", out_addr, out_data, e.addr, e.data); end
        end
      end
      if (done) begin done_cnt = cnt; break; end
    end
    total++; if (done_cnt != PASS_CYC) begin bad++; $display("FAIL small_done_time: got %0d want %0d", done_cnt, PASS_CYC); end
    total++; if (nx != 4 || last_x != done_cnt - 1) begin bad++; $display("FAIL small_count: got n=%0d last=%0d want n=4 last=%0d", nx, last_x, done_cnt - 1); end
    @(negedge clk);
    total++; if ({done, busy} !== 2'b00) begin bad++; $display("FAIL small_done_pulse: got %b want 00", {done, busy}); end
  endtask

  task automatic test_addr_sweep();
    int rcnt = 0, idx, ea;
    logic fin = 1'b0;
    @(negedge clk);
    start8 = 1'b1;
    for (int i = 0; i < 16 * (F * F + 3) + 20; i++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (rd_en8) begin
        if (rcnt / 25 == 9) begin
          idx = rcnt % 25;
          ea  = (2 + idx / 5) * 8 + 1 + idx % 5;
          total++; if (rd_addr8 !== AW8'(ea)) begin bad++; $display("FAIL sweep_addr[%0d]: got %0d want %0d", idx, rd_addr8, ea); end
        end
        rcnt++;
      end
      if (done8) begin fin = 1'b1; break; end
    end
    total++; if (!fin || rcnt != 16 * 25) begin bad++; $display("FAIL sweep_reads: got %0d done=%b want 400 done=1", rcnt, fin); end
  endtask

  task automatic test_backpressure();
    exp_t e;
    logic [ZW-1:0]  hd;
    logic [OAW-1:0] ha;
    int   nx = 0;
    logic fin = 1'b0, seen = 1'b0;
    q.delete();
    push_pass();
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid) begin seen = 1'b1; break; end
    end
    total++; if (!seen) begin bad++; $display("FAIL bp_valid: got 0 want 1"); end
    hd = out_data;
    ha = out_addr;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++; if ({out_valid, rd_en, out_data, out_addr} !== {2'b10, hd, ha}) begin bad++; $display("FAIL bp_stall[%0d]: got v=%b rd=%b d=%0d a=%0d want v=1 rd=0 d=%0d a=%0d", i, out_valid, rd_en, out_data, out_addr, hd, ha); end
    end
    out_ready = 1'b1;
    for (int i = 0; i < PASS_CYC + 20; i++) begin
      if (out_valid && out_ready) begin
        nx++; total++;
        if (q.size() == 0) begin bad++; $display("FAIL bp_result: unexpected addr=%0d", out_addr); end
        else begin
          e = q.pop_front();
          if (out_addr !== e.addr || out_data !== e.data) begin bad++; $display("FAIL bp_result: got addr=%0d data=%0d want addr=%0d data=%0d", out_addr, out_data, e.addr, e.data); end
        end
      end
      @(negedge clk);
      if (i == 0) begin
        total++; if ({rd_en, out_valid} !== 2'b10) begin bad++; $display("FAIL bp_resume: got rd=%b v=%b want rd=1 v=0", rd_en, out_valid); end
      end
      if (done) begin fin = 1'b1; break; end
    end
    total++; if (!fin || nx != 4 || q.size() != 0) begin bad++; $display("FAIL bp_pass: got n=%0d done=%b left=%0d want n=4 done=1 left=0", nx, fin, q.size()); end
  endtask

  task automatic test_abort();
    exp_t e;
    int   nx = 0, fcnt = 0;
    logic fin = 1'b0, any = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) nx++;
      if (nx == 1 && rd_en) fcnt++;
      if (fcnt == 5) break;
    end
    total++; if (fcnt != 5) begin bad++; $display("FAIL abort_reach: got fetch=%0d want 5", fcnt); end
    rst_n = 1'b0;
    #1;
    total++; if ({busy, done, rd_en, win_valid, out_valid, rd_addr, out_addr, out_data} !== '0 || win_x !== '0) begin bad++; $display("FAIL abort_reset: got b=%b rd=%b v=%b a=%0d want all 0", busy, rd_en, out_valid, out_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      any = any | done | busy | out_valid;
    end
    total++; if (any) begin bad++; $display("FAIL abort_quiet: got activity=1 want 0"); end
    q.delete();
    push_pass();
    nx = 0;
    start = 1'b1;
    for (int i = 0; i < PASS_CYC + 20; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) begin
        nx++; total++;
        if (q.size() == 0) begin bad++; $display("FAIL abort_rerun: unexpected addr=%0d", out_addr); end
        else begin
          e = q.pop_front();
          if (out_addr !== e.addr || out_data !== e.data) begin bad++; $display("FAIL abort_rerun: got addr=%0d data=%0d want addr=%0d data=%0d", out_addr, out_data, e.addr, e.data); end
        end
      end
      if (done) begin fin = 1'b1; break; end
    end
    total++; if (!fin || nx != 4) begin bad++; $display("FAIL abort_rerun_pass: got n=%0d done=%b want n=4 done=1", nx, fin); end
  endtask

  task automatic test_start_busy();
    exp_t e;
    int   cnt = 0, nx = 0, done_cnt = -1;
    q.delete();
    push_pass();
    @(negedge clk);
    out_ready = 1'b1;
    start = 1'b1;
    for (int i = 0; i < PASS_CYC + 20; i++) begin
      @(negedge clk);
      cnt++;
      start = (nx < 3) ? 1'($urandom) : 1'b0;
      if (out_valid && out_ready) begin
        nx++; total++;
        if (q.size() == 0) begin bad++; $display("FAIL busy_result: unexpected addr=%0d", out_addr); end
        else begin
          e = q.pop_front();
          if (out_addr !== e.addr || out_data !== e.data) begin bad++; $display("FAIL busy_result: got addr=%0d data=%0d want addr=%0d data=%0d", out_addr, out_data, e.addr, e.data); end
        end
      end
      if (done) begin done_cnt = cnt; break; end
    end
    start = 1'b0;
    total++; if (done_cnt != PASS_CYC || nx != 4) begin bad++; $display("FAIL busy_timing: got t=%0d n=%0d want t=%0d n=4", done_cnt, nx, PASS_CYC); end
    @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    start8     = 1'b0;
    out_ready8 = 1'b1;
    test_reset();
    test_small_map();
    test_addr_sweep();
    test_backpressure();
    test_abort();
    test_start_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
